// File: rtl/bram_read_arbiter_pkg.sv
// Shared constants and FSM state type for the BRAM read-port arbiter.
// Latency: none (declarations only).
// Backpressure: not applicable.
package bram_axi_pkg;

   localparam int ADDR_W = 18;
   localparam int DATA_W = 16;

   localparam logic [1:0] RESP_OKAY   = 2'b00;
   localparam logic [1:0] RESP_SLVERR = 2'b10;

   // One read in flight: accept address, drive slave AR, wait slave R, hand data back.
   typedef enum logic [1:0] {
      IDLE = 2'd0,
      ADDR = 2'd1,
      DATA = 2'd2,
      RESP = 2'd3
   } arb_state_e;

   // Width of an index over n requesters, never narrower than one bit.
   function automatic int idx_w(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/bram_read_arbiter_rr_arbiter.sv
// Combinational grant selection: one-hot grant plus encoded index over req_i.
// Latency: zero cycles (purely combinational).
// Backpressure: none; caller decides when the grant is consumed.
// BRAM_ARB_FIXED_PRIORITY_EN: defined -> lowest index wins and ptr_i is ignored;
// undefined -> first requester at index >= ptr_i wins, wrapping around.
module rr_arbiter #(
   parameter int NUM_MASTERS = 2,
   parameter int PTR_W       = (NUM_MASTERS > 1) ? $clog2(NUM_MASTERS) : 1
) (
   input  logic [NUM_MASTERS-1:0] req_i,
   input  logic [PTR_W-1:0]       ptr_i,
   output logic [NUM_MASTERS-1:0] grant_o,
   output logic [PTR_W-1:0]       grant_idx_o
);

   logic             found;
   logic [PTR_W-1:0] cand_idx;

`ifdef BRAM_ARB_FIXED_PRIORITY_EN
   // Pointer has no effect when the lowest index always has priority.
   logic unused_ptr;
   assign unused_ptr = ^ptr_i;

   // Scan upward from index 0; the first requester found wins.
   always_comb begin
      grant_o     = '0;
      grant_idx_o = '0;
      found       = 1'b0;
      cand_idx    = '0;
      for (int i = 0; i < NUM_MASTERS; i++) begin
         cand_idx = PTR_W'(i);
         if (!found && req_i[cand_idx]) begin
            found             = 1'b1;
            grant_o[cand_idx] = 1'b1;
            grant_idx_o       = cand_idx;
         end
      end
   end
`else
   // Scan from the pointer with wrap; the first requester found wins.
   always_comb begin
      grant_o     = '0;
      grant_idx_o = '0;
      found       = 1'b0;
      cand_idx    = '0;
      for (int i = 0; i < NUM_MASTERS; i++) begin
         cand_idx = PTR_W'((int'(ptr_i) + i) % NUM_MASTERS);
         if (!found && req_i[cand_idx]) begin
            found             = 1'b1;
            grant_o[cand_idx] = 1'b1;
            grant_idx_o       = cand_idx;
         end
      end
   end
`endif

endmodule

// File: rtl/bram_read_arbiter.sv
// Shares one AXI-lite read port of the sprite/tile BRAM among NUM_MASTERS requesters.
// Latency: m_ar handshake T -> s_ar_valid T+1; zero-wait slave gives m_r_valid at T+3.
// Backpressure: slave AR/R stalls and master R stalls hold the current state; no timeout.
// BRAM_ARB_FIXED_PRIORITY_EN: defined -> lowest valid index always wins, pointer stays 0.
module bram_read_arbiter #(
   parameter int NUM_MASTERS = 2,
   parameter int ADDR_W      = bram_axi_pkg::ADDR_W,
   parameter int DATA_W      = bram_axi_pkg::DATA_W
) (
   input  logic                          a_clk,
   input  logic                          a_rst,
   // requester side
   input  logic [NUM_MASTERS-1:0]        m_ar_valid,
   output logic [NUM_MASTERS-1:0]        m_ar_ready,
   input  logic [NUM_MASTERS*ADDR_W-1:0] m_ar_addr,
   input  logic [NUM_MASTERS-1:0]        m_ar_prot,
   output logic [NUM_MASTERS-1:0]        m_r_valid,
   input  logic [NUM_MASTERS-1:0]        m_r_ready,
   output logic [DATA_W-1:0]             m_r_data,
   output logic [1:0]                    m_r_resp,
   // BRAM side
   output logic                          s_ar_valid,
   input  logic                          s_ar_ready,
   output logic [ADDR_W-1:0]             s_ar_addr,
   output logic                          s_ar_prot,
   input  logic                          s_r_valid,
   output logic                          s_r_ready,
   input  logic [DATA_W-1:0]             s_r_data,
   input  logic [1:0]                    s_r_resp
);

   import bram_axi_pkg::*;

   localparam int PTR_W = idx_w(NUM_MASTERS);

   arb_state_e        state_q, state_d;
   logic [PTR_W-1:0]  ptr_q, ptr_d;
   logic [PTR_W-1:0]  gnt_idx_q, gnt_idx_d;
   logic [ADDR_W-1:0] addr_q, addr_d;
   logic              prot_q, prot_d;
   logic [DATA_W-1:0] rdata_q, rdata_d;
   logic [1:0]        rresp_q, rresp_d;

   logic [NUM_MASTERS-1:0] arb_grant;
   logic [PTR_W-1:0]       arb_idx;
   logic [ADDR_W-1:0]      sel_addr;
   logic                   sel_prot;
   logic                   win_r_ready;

   rr_arbiter #(
      .NUM_MASTERS (NUM_MASTERS),
      .PTR_W       (PTR_W)
   ) u_rr_arbiter (
      .req_i       (m_ar_valid),
      .ptr_i       (ptr_q),
      .grant_o     (arb_grant),
      .grant_idx_o (arb_idx)
   );

   // Pick the current arbitration winner's address and prot from the packed buses.
   always_comb begin
      sel_addr = '0;
      sel_prot = 1'b0;
      for (int i = 0; i < NUM_MASTERS; i++) begin
         if (arb_idx == PTR_W'(i)) begin
            sel_addr = m_ar_addr[i*ADDR_W +: ADDR_W];
            sel_prot = m_ar_prot[i];
         end
      end
   end

   // Read-data accept from whichever master owns the in-flight read.
   always_comb begin
      win_r_ready = 1'b0;
      for (int i = 0; i < NUM_MASTERS; i++) begin
         if (gnt_idx_q == PTR_W'(i)) begin
            win_r_ready = m_r_ready[i];
         end
      end
   end

   // Next-state and datapath capture for the single outstanding read.
   always_comb begin
      state_d   = state_q;
      ptr_d     = ptr_q;
      gnt_idx_d = gnt_idx_q;
      addr_d    = addr_q;
      prot_d    = prot_q;
      rdata_d   = rdata_q;
      rresp_d   = rresp_q;
      case (state_q)
         IDLE: begin
            if (|m_ar_valid) begin
               gnt_idx_d = arb_idx;
               addr_d    = sel_addr;
               prot_d    = sel_prot;
               state_d   = ADDR;
            end
         end
         ADDR: begin
            // s_ar_valid is high throughout this state, so ready alone completes it.
            if (s_ar_ready) begin
               state_d = DATA;
            end
         end
         DATA: begin
            if (s_r_valid) begin
               rdata_d = s_r_data;
               rresp_d = s_r_resp;
               state_d = RESP;
            end
         end
         RESP: begin
            if (win_r_ready) begin
`ifdef BRAM_ARB_FIXED_PRIORITY_EN
               ptr_d = '0;
`else
               // Rotate priority to the master after the one just served.
               if (gnt_idx_q == PTR_W'(NUM_MASTERS - 1)) begin
                  ptr_d = '0;
               end else begin
                  ptr_d = gnt_idx_q + PTR_W'(1);
               end
`endif
               state_d = IDLE;
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   // State and capture registers; reset abandons any in-flight read.
   always_ff @(posedge a_clk or posedge a_rst) begin
      if (a_rst) begin
         state_q   <= IDLE;
         ptr_q     <= '0;
         gnt_idx_q <= '0;
         addr_q    <= '0;
         prot_q    <= 1'b0;
         rdata_q   <= '0;
         rresp_q   <= '0;
      end else begin
         state_q   <= state_d;
         ptr_q     <= ptr_d;
         gnt_idx_q <= gnt_idx_d;
         addr_q    <= addr_d;
         prot_q    <= prot_d;
         rdata_q   <= rdata_d;
         rresp_q   <= rresp_d;
      end
   end

   // Address accept only while idle, gated off during reset.
   assign m_ar_ready = ((state_q == IDLE) && !a_rst) ? arb_grant : '0;

   // Slave-side handshakes follow the state directly, so they clear with reset.
   assign s_ar_valid = (state_q == ADDR);
   assign s_ar_addr  = addr_q;
   assign s_ar_prot  = prot_q;
   assign s_r_ready  = (state_q == DATA);

   // Return data to the winner only; shared data/resp buses come from capture registers.
   always_comb begin
      m_r_valid = '0;
      for (int i = 0; i < NUM_MASTERS; i++) begin
         m_r_valid[i] = (state_q == RESP) && (gnt_idx_q == PTR_W'(i));
      end
   end

   assign m_r_data = rdata_q;
   assign m_r_resp = rresp_q;

endmodule

// File: tb/tb_bram_read_arbiter.sv
// Directed bench for bram_read_arbiter with a small BRAM responder model.
// Inputs change 3 time units after each rising edge; the responder acts on falling edges.
// Honours BRAM_ARB_FIXED_PRIORITY_EN for the contention expectations.
module tb_bram_read_arbiter;

   localparam int NM = 2;
   localparam int AW = 18;
   localparam int DW = 16;

   logic             a_clk = 1'b0;
   logic             a_rst;
   logic [NM-1:0]    m_ar_valid;
   logic [NM-1:0]    m_ar_ready;
   logic [NM*AW-1:0] m_ar_addr;
   logic [NM-1:0]    m_ar_prot;
   logic [NM-1:0]    m_r_valid;
   logic [NM-1:0]    m_r_ready;
   logic [DW-1:0]    m_r_data;
   logic [1:0]       m_r_resp;
   logic             s_ar_valid;
   logic             s_ar_ready;
   logic [AW-1:0]    s_ar_addr;
   logic             s_ar_prot;
   logic             s_r_valid;
   logic             s_r_ready;
   logic [DW-1:0]    s_r_data;
   logic [1:0]       s_r_resp;

   int n_chk = 0;
   int n_err = 0;

   // responder configuration written by the stimulus process
   int         ar_stall_cfg;
   int         r_stall_cfg;
   logic [1:0] resp_cfg;

   // responder private state
   logic [DW-1:0] mem [0:4095];
   logic          pend;
   logic          ar_seen;
   logic          r_seen;
   int            ar_cnt;
   int            r_cnt;
   logic [AW-1:0] paddr;

   always #5 a_clk = ~a_clk;

   bram_read_arbiter #(
      .NUM_MASTERS (NM),
      .ADDR_W      (AW),
      .DATA_W      (DW)
   ) dut (
      .a_clk      (a_clk),
      .a_rst      (a_rst),
      .m_ar_valid (m_ar_valid),
      .m_ar_ready (m_ar_ready),
      .m_ar_addr  (m_ar_addr),
      .m_ar_prot  (m_ar_prot),
      .m_r_valid  (m_r_valid),
      .m_r_ready  (m_r_ready),
      .m_r_data   (m_r_data),
      .m_r_resp   (m_r_resp),
      .s_ar_valid (s_ar_valid),
      .s_ar_ready (s_ar_ready),
      .s_ar_addr  (s_ar_addr),
      .s_ar_prot  (s_ar_prot),
      .s_r_valid  (s_r_valid),
      .s_r_ready  (s_r_ready),
      .s_r_data   (s_r_data),
      .s_r_resp   (s_r_resp)
   );

   // BRAM responder: optional AR stall, optional R delay, word index = addr[11:0].
   always @(negedge a_clk) begin
      if (a_rst) begin
         s_ar_ready = 1'b0;
         s_r_valid  = 1'b0;
         s_r_data   = '0;
         s_r_resp   = '0;
         pend       = 1'b0;
         ar_seen    = 1'b0;
         r_seen     = 1'b0;
         ar_cnt     = 0;
         r_cnt      = 0;
         paddr      = '0;
      end else begin
         if (s_r_ready && pend) begin
            if (!r_seen) begin
               r_seen = 1'b1;
               r_cnt  = r_stall_cfg;
            end
            s_r_valid = (r_cnt == 0);
            if (r_cnt > 0) r_cnt--;
            s_r_data = mem[paddr[11:0]];
            s_r_resp = resp_cfg;
         end else begin
            s_r_valid = 1'b0;
            if (!s_r_ready) begin
               pend   = 1'b0;
               r_seen = 1'b0;
            end
         end
         if (s_ar_valid) begin
            if (!ar_seen) begin
               ar_seen = 1'b1;
               ar_cnt  = ar_stall_cfg;
            end
            s_ar_ready = (ar_cnt == 0);
            if (ar_cnt > 0) ar_cnt--;
            if (s_ar_ready) begin
               pend  = 1'b1;
               paddr = s_ar_addr;
            end
         end else begin
            s_ar_ready = 1'b0;
            ar_seen    = 1'b0;
         end
      end
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_chk++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
      end
   endtask

   task automatic nxt();
      @(posedge a_clk);
      #3;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog expired");
   end

   initial begin
      logic [1:0]  exp_g;
      logic [15:0] exp_d;

      mem[12'h648] = 16'h55aa;
      mem[12'h000] = 16'habcd;
      mem[12'hfff] = 16'hbabe;
      mem[12'ha55] = 16'hc0fe;

      a_rst        = 1'b1;
      m_ar_valid   = '0;
      m_ar_addr    = '0;
      m_ar_prot    = '0;
      m_r_ready    = 2'b11;
      ar_stall_cfg = 0;
      r_stall_cfg  = 0;
      resp_cfg     = 2'b00;

      // ---- reset values, with requests pending to show ready is gated
      repeat (2) @(posedge a_clk);
      #3;
      m_ar_valid = 2'b11;
      #1;
      chk("rst_m_ar_ready", 32'(m_ar_ready), 32'h0);
      chk("rst_s_ar_valid", 32'(s_ar_valid), 32'h0);
      chk("rst_s_ar_addr",  32'(s_ar_addr),  32'h0);
      chk("rst_s_ar_prot",  32'(s_ar_prot),  32'h0);
      chk("rst_s_r_ready",  32'(s_r_ready),  32'h0);
      chk("rst_m_r_valid",  32'(m_r_valid),  32'h0);
      chk("rst_m_r_data",   32'(m_r_data),   32'h0);
      chk("rst_m_r_resp",   32'(m_r_resp),   32'h0);
      m_ar_valid = '0;
      a_rst      = 1'b0;
      nxt();

      // ---- single read from master0
      m_ar_addr  = {18'h00000, 18'h00648};
      m_ar_prot  = 2'b01;
      m_ar_valid = 2'b01;
      #1;
      chk("t1_ar_ready", 32'(m_ar_ready), 32'h1);
      nxt();
      m_ar_valid = '0;
      #1;
      chk("t1_s_ar_valid", 32'(s_ar_valid), 32'h1);
      chk("t1_s_ar_addr",  32'(s_ar_addr),  32'h648);
      chk("t1_s_ar_prot",  32'(s_ar_prot),  32'h1);
      chk("t1_ar_ready_busy", 32'(m_ar_ready), 32'h0);
      nxt();
      chk("t1_s_r_ready", 32'(s_r_ready), 32'h1);
      chk("t1_no_early_rvalid", 32'(m_r_valid), 32'h0);
      nxt();
      chk("t1_m_r_valid", 32'(m_r_valid), 32'h1);
      chk("t1_m_r_data",  32'(m_r_data),  32'h55aa);
      chk("t1_m_r_resp",  32'(m_r_resp),  32'h0);
      nxt();
      chk("t1_idle_rvalid", 32'(m_r_valid), 32'h0);

      // ---- contention: reset pointer, both masters request continuously
      a_rst = 1'b1;
      #1;
      a_rst = 1'b0;
      m_ar_addr  = {18'h00fff, 18'h00000};
      m_ar_prot  = 2'b00;
      m_ar_valid = 2'b11;
      for (int k = 0; k < 4; k++) begin
`ifdef BRAM_ARB_FIXED_PRIORITY_EN
         exp_g = 2'b01;
         exp_d = 16'habcd;
`else
         exp_g = (k % 2 == 0) ? 2'b01 : 2'b10;
         exp_d = (k % 2 == 0) ? 16'habcd : 16'hbabe;
`endif
         #1;
         chk($sformatf("cont%0d_grant", k), 32'(m_ar_ready), 32'(exp_g));
         nxt();
         nxt();
         nxt();
         chk($sformatf("cont%0d_rvalid", k), 32'(m_r_valid), 32'(exp_g));
         chk($sformatf("cont%0d_rdata", k),  32'(m_r_data),  32'(exp_d));
         nxt();
      end
      m_ar_valid = '0;
      nxt();

      // ---- master1 holds off read data for 5 cycles while master0 waits
      m_ar_valid = 2'b10;
      m_r_ready  = 2'b01;
      #1;
      chk("bp_grant1", 32'(m_ar_ready), 32'h2);
      nxt();
      m_ar_valid = 2'b01;
      #1;
      chk("bp_no_accept_addr", 32'(m_ar_ready), 32'h0);
      nxt();
      nxt();
      for (int i = 0; i < 5; i++) begin
         chk($sformatf("bp%0d_rvalid", i), 32'(m_r_valid), 32'h2);
         chk($sformatf("bp%0d_rdata", i),  32'(m_r_data),  32'hbabe);
         chk($sformatf("bp%0d_no_s_ar", i), 32'(s_ar_valid), 32'h0);
         chk($sformatf("bp%0d_no_ar_rdy", i), 32'(m_ar_ready), 32'h0);
         nxt();
      end
      m_r_ready = 2'b11;
      nxt();
      chk("bp_after_grant0", 32'(m_ar_ready), 32'h1);
      nxt();
      m_ar_valid = '0;
      nxt();
      nxt();
      chk("bp_m0_rvalid", 32'(m_r_valid), 32'h1);
      chk("bp_m0_rdata",  32'(m_r_data),  32'habcd);
      nxt();

      // ---- reset while waiting for read data
      m_ar_addr   = {18'h00648, 18'h00a55};
      m_ar_valid  = 2'b10;
      r_stall_cfg = 3;
      #1;
      chk("rr_grant1", 32'(m_ar_ready), 32'h2);
      nxt();
      m_ar_valid = '0;
      nxt();
      chk("rr_in_data", 32'(s_r_ready), 32'h1);
      m_ar_valid = 2'b01;
      a_rst      = 1'b1;
      #1;
      chk("rr_s_r_ready",  32'(s_r_ready),  32'h0);
      chk("rr_s_ar_valid", 32'(s_ar_valid), 32'h0);
      chk("rr_s_ar_addr",  32'(s_ar_addr),  32'h0);
      chk("rr_m_r_valid",  32'(m_r_valid),  32'h0);
      chk("rr_m_r_data",   32'(m_r_data),   32'h0);
      chk("rr_m_ar_ready", 32'(m_ar_ready), 32'h0);
      nxt();
      a_rst       = 1'b0;
      r_stall_cfg = 0;
      #1;
      chk("rr_fresh_grant0", 32'(m_ar_ready), 32'h1);
      nxt();
      m_ar_valid = '0;
      #1;
      chk("rr_fresh_addr", 32'(s_ar_addr), 32'ha55);
      nxt();
      nxt();
      chk("rr_fresh_rvalid", 32'(m_r_valid), 32'h1);
      chk("rr_fresh_rdata",  32'(m_r_data),  32'hc0fe);
      nxt();

      // ---- slave holds AR ready low for 10 cycles; error response passes through
      ar_stall_cfg = 10;
      resp_cfg     = 2'b10;
      m_ar_addr    = {18'h00648, 18'h00000};
      m_ar_valid   = 2'b10;
      #1;
      chk("st_grant1", 32'(m_ar_ready), 32'h2);
      nxt();
      m_ar_valid = '0;
      for (int i = 0; i < 10; i++) begin
         chk($sformatf("st%0d_s_ar_valid", i), 32'(s_ar_valid), 32'h1);
         chk($sformatf("st%0d_s_ar_addr", i),  32'(s_ar_addr),  32'h648);
         nxt();
      end
      chk("st_last_addr_cycle", 32'(s_ar_valid), 32'h1);
      nxt();
      chk("st_data_state", 32'(s_r_ready), 32'h1);
      nxt();
      chk("st_rvalid", 32'(m_r_valid), 32'h2);
      chk("st_rdata",  32'(m_r_data),  32'h55aa);
      chk("st_rresp",  32'(m_r_resp),  32'h2);
      nxt();
      chk("st_idle_rvalid", 32'(m_r_valid), 32'h0);

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

endmodule
